// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage
// Registered instruction-decode control stage. Decodes the RISC-V opcode into
// datapath control strobes and holds them, with the rd/rs1/rs2 fields, in a
// one-entry ID/EX register guarded by a valid/ready handshake. Detects
// load-use hazards (one bubble), supports a synchronous flush, optionally
// decodes LUI/AUIPC, flags illegal opcodes and counts stall cycles.
//
// Parameters:
//   ENABLE_UPPER  1 decodes LUI/AUIPC, 0 reports them as illegal
//   CNT_W         width of the saturating stall counter
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    upstream handshake (in_ready is combinational)
//   instr                 instruction word from the IF/ID register
//   flush                 kills the held entry and the incoming instruction
//   out_valid, out_ready  downstream handshake with the execute stage
//   alu_src .. alu_op     registered control strobes for the held entry
//   rd, rs1, rs2          registered register-address fields
//   illegal               held entry had an unrecognised opcode
//   stall_count           saturating count of load-use hazard cycles
module id_ctrl_stage #(
    parameter bit ENABLE_UPPER = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             alu_src,
    output logic             alu_a_pc,
    output logic [1:0]       result_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic [1:0]       alu_op,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_IALU   = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef struct packed {
        logic       alu_src;
        logic       alu_a_pc;
        logic [1:0] result_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t      dec;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rd_in;
    logic [4:0] rs1_in;
    logic [4:0] rs2_in;
    logic       hazard;
    logic       accept;

    ctrl_t      ctrl_q;
    logic [4:0] rd_q;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;

    // funct3/funct7 are decoded by the execute stage, not here.
    logic unused_funct;
    assign unused_funct = ^{instr[31:25], instr[14:12]};

    assign rd_in  = instr[11:7];
    assign rs1_in = instr[19:15];
    assign rs2_in = instr[24:20];

    // Opcode decode. Unknown opcodes fall through to all-zero controls with
    // illegal set, so no X ever reaches the register.
    always_comb begin
        // NOTE: every output of this block gets a default first; any path that
        // left one unassigned would infer a latch.
        dec         = '0;
        dec.illegal = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        case (instr[6:0])
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_IALU: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b11;
                uses_rs1      = 1'b1;
            end
            OP_JALR: begin
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_JAL: begin
                dec.alu_src    = 1'b1;
                dec.alu_a_pc   = 1'b1;
                dec.result_src = 2'b10;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
            end
            OP_LUI: begin
                if (ENABLE_UPPER) begin
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b11;
                    dec.reg_write  = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (ENABLE_UPPER) begin
                    dec.alu_src   = 1'b1;
                    dec.alu_a_pc  = 1'b1;
                    dec.reg_write = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // A held load whose destination feeds the presented instruction cannot
    // forward in time; hold the consumer back for one cycle. Writes to x0
    // never create a dependency.
    assign hazard = out_valid & ctrl_q.mem_read & (rd_q != 5'd0) & in_valid &
                    ((uses_rs1 & (rs1_in == rd_q)) | (uses_rs2 & (rs2_in == rd_q)));

    assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // NOTE: the whole ID/EX register is reset, not just out_valid, because
    // downstream expects all-zero controls whenever the entry is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else if (flush) begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctrl_q    <= dec;
            rd_q      <= rd_in;
            rs1_q     <= rs1_in;
            rs2_q     <= rs2_in;
        end else if (out_valid && out_ready) begin
            // Consumed with nothing behind it: leave a clean zero bubble.
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end
    end

    // Flush overrides a hazard, so that cycle is not counted as a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (hazard && !flush && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign alu_src    = ctrl_q.alu_src;
    assign alu_a_pc   = ctrl_q.alu_a_pc;
    assign result_src = ctrl_q.result_src;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign alu_op     = ctrl_q.alu_op;
    assign illegal    = ctrl_q.illegal;
    assign rd         = rd_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage
// Drives two instances of id_ctrl_stage with identical stimulus: one with the
// default parameters and one with ENABLE_UPPER=0, CNT_W=2. A reference model
// keeps the held instruction word and recomputes every output from the decode
// table each cycle; directed literal checks pin the model on known sequences.
module tb_id_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, alu_src_a, alu_a_pc_a, reg_write_a;
    logic        mem_read_a, mem_write_a, branch_a, jump_a, illegal_a;
    logic [1:0]  result_src_a, alu_op_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [15:0] stall_a;

    logic        in_ready_b, out_valid_b, alu_src_b, alu_a_pc_b, reg_write_b;
    logic        mem_read_b, mem_write_b, branch_b, jump_b, illegal_b;
    logic [1:0]  result_src_b, alu_op_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [1:0]  stall_b;

    int n_tests = 0;
    int n_fail  = 0;

    id_ctrl_stage u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
        .alu_src(alu_src_a), .alu_a_pc(alu_a_pc_a), .result_src(result_src_a),
        .reg_write(reg_write_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .branch(branch_a), .jump(jump_a), .alu_op(alu_op_a), .rd(rd_a),
        .rs1(rs1_a), .rs2(rs2_a), .illegal(illegal_a), .stall_count(stall_a)
    );

    id_ctrl_stage #(.ENABLE_UPPER(1'b0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .alu_src(alu_src_b), .alu_a_pc(alu_a_pc_b), .result_src(result_src_b),
        .reg_write(reg_write_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .branch(branch_b), .jump(jump_b), .alu_op(alu_op_b), .rd(rd_b),
        .rs1(rs1_b), .rs2(rs2_b), .illegal(illegal_b), .stall_count(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Control word: {alu_src, alu_a_pc, result_src, reg_write, mem_read,
    //                mem_write, branch, jump, alu_op, illegal}
    function automatic logic [11:0] ref_decode(input logic [31:0] i, input bit upper);
        case (i[6:0])
            7'b0110011: return 12'b0_0_00_1_0_0_0_0_10_0;
            7'b0000011: return 12'b1_0_01_1_1_0_0_0_00_0;
            7'b0100011: return 12'b1_0_00_0_0_1_0_0_00_0;
            7'b1100011: return 12'b0_0_00_0_0_0_1_0_01_0;
            7'b0010011: return 12'b1_0_00_1_0_0_0_0_11_0;
            7'b1100111: return 12'b1_0_10_1_0_0_0_1_00_0;
            7'b1101111: return 12'b1_1_10_1_0_0_0_1_00_0;
            7'b0110111: return upper ? 12'b1_0_11_1_0_0_0_0_00_0 : 12'b0000_0000_0001;
            7'b0010111: return upper ? 12'b1_1_00_1_0_0_0_0_00_0 : 12'b0000_0000_0001;
            default:    return 12'b0000_0000_0001;
        endcase
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    int          m_stall_a = 0;
    int          m_stall_b = 0;

    function automatic bit m_hazard();
        logic [4:0] drd;
        drd = m_instr[11:7];
        return m_valid && (m_instr[6:0] == 7'b0000011) && (drd != 0) && in_valid &&
               ((reads_rs1(instr[6:0]) && instr[19:15] == drd) ||
                (reads_rs2(instr[6:0]) && instr[24:20] == drd));
    endfunction

    function automatic bit m_ready();
        return !flush && !m_hazard() && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_instr   <= '0;
            m_stall_a <= 0;
            m_stall_b <= 0;
        end else begin
            if (m_hazard() && !flush) begin
                if (m_stall_a < 65535) m_stall_a <= m_stall_a + 1;
                if (m_stall_b < 3)     m_stall_b <= m_stall_b + 1;
            end
            if (flush)                         m_valid <= 1'b0;
            else if (in_valid && m_ready()) begin
                m_valid <= 1'b1;
                m_instr <= instr;
            end else if (m_valid && out_ready) m_valid <= 1'b0;
        end
    end

    function automatic logic [28:0] expect_vec(input bit upper);
        logic [11:0] c;
        logic [14:0] f;
        c = m_valid ? ref_decode(m_instr, upper) : 12'b0;
        f = m_valid ? {m_instr[11:7], m_instr[19:15], m_instr[24:20]} : 15'b0;
        return {m_valid, c, f, m_ready()};
    endfunction

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("vec_a", {alu_src_a ? 1'b0 : 1'b0, out_valid_a, alu_src_a, alu_a_pc_a, result_src_a,
                            reg_write_a, mem_read_a, mem_write_a, branch_a, jump_a, alu_op_a,
                            illegal_a, rd_a, rs1_a, rs2_a, in_ready_a},
                  {1'b0, expect_vec(1'b1)});
            check("vec_b", {out_valid_b, alu_src_b, alu_a_pc_b, result_src_b,
                            reg_write_b, mem_read_b, mem_write_b, branch_b, jump_b, alu_op_b,
                            illegal_b, rd_b, rs1_b, rs2_b, in_ready_b},
                  expect_vec(1'b0));
            check("stall_a", stall_a, m_stall_a);
            check("stall_b", stall_b, m_stall_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] i, input logic fl, input logic ordy);
        in_valid  = v;
        instr     = i;
        flush     = fl;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            w[6:0]   = ops[$urandom_range(0, 9)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
        end
        return w;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("reset_out_valid", out_valid_a, 1'b0);
        check("reset_stall", stall_a, 16'd0);
        check("reset_illegal", {illegal_a, reg_write_a, rd_a}, 7'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 1'b0, 1'b1);
        tick();
        check("add_fields", {out_valid_a, alu_op_a, reg_write_a, result_src_a, alu_src_a,
                             rd_a, rs1_a, rs2_a, illegal_a},
              {1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0});

        // lw x5 then dependent add x6,x5,x7: one stall, one bubble
        drive(1'b1, 32'h0000A283, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h00728333, 1'b0, 1'b1);
        check("lu_hazard_ready", in_ready_a, 1'b0);
        tick();
        check("lu_bubble", out_valid_a, 1'b0);
        check("lu_ready_after", in_ready_a, 1'b1);
        tick();
        check("lu_dep_out", {out_valid_a, rd_a}, {1'b1, 5'd6});
        check("lu_stall_a", stall_a, 16'd1);
        check("lu_stall_b", stall_b, 2'd1);

        // lw x0: no dependency possible
        drive(1'b1, 32'h0000A003, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h00728333, 1'b0, 1'b1);
        check("x0_ready", in_ready_a, 1'b1);
        tick();
        check("x0_out", {out_valid_a, rd_a, stall_a}, {1'b1, 5'd6, 16'd1});

        // backpressure for 3 cycles
        drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", in_ready_a, 1'b0);
            check("bp_hold", {out_valid_a, rd_a, reg_write_a, alu_op_a}, {1'b1, 5'd6, 1'b1, 2'b10});
            tick();
        end
        drive(1'b1, 32'h002081B3, 1'b0, 1'b1);
        check("bp_release_ready", in_ready_a, 1'b1);
        tick();
        check("bp_release_out", {out_valid_a, rd_a}, {1'b1, 5'd3});

        // flush with a valid entry and a valid input
        drive(1'b1, 32'h0000A283, 1'b1, 1'b1);
        tick();
        check("flush_out", {out_valid_a, mem_read_a, reg_write_a, alu_op_a, rd_a, rs1_a},
              17'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("flush_dropped", out_valid_a, 1'b0);

        // illegal opcode and LUI with/without upper decode
        drive(1'b1, 32'h0000007F, 1'b0, 1'b1);
        tick();
        check("illegal_7f", {out_valid_a, illegal_a, reg_write_a, mem_write_a}, 4'b1100);
        drive(1'b1, 32'h000010B7, 1'b0, 1'b1);
        tick();
        check("lui_a", {illegal_a, result_src_a, reg_write_a, rd_a}, {1'b0, 2'b11, 1'b1, 5'd1});
        check("lui_b", {illegal_b, result_src_b, reg_write_b}, {1'b1, 2'b00, 1'b0});

        // 5 hazard cycles under backpressure: CNT_W=2 saturates at 3
        drive(1'b1, 32'h0000A283, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h00728333, 1'b0, 1'b0);
        repeat (5) tick();
        check("sat_stall_a", stall_a, 16'd6);
        check("sat_stall_b", stall_b, 2'd3);
        check("sat_ready", in_ready_a, 1'b0);

        // asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("arst_a", {out_valid_a, mem_read_a, rd_a, stall_a}, 23'd0);
        check("arst_b", {out_valid_b, stall_b}, 3'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            tick();
        end

        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
